// File: rtl/sd_wb2ahb_master.sv
// Wishbone classic master to AHB5 single-transfer bridge for the SD controller DMA port.
// Optional macro SD_WB2AHB_ERR_EN: report AHB errors and illegal sel on wb_err_o instead of wb_ack_o.
module sd_wb2ahb_master #(
    parameter int         W_ADDR    = 32,
    parameter int         W_DATA    = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [W_ADDR-1:0] wb_adr_i,
    input  logic [W_DATA-1:0] wb_dat_i,
    output logic [W_DATA-1:0] wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [W_ADDR-1:0] haddr,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic              hmastlock,
    output logic              hexcl,
    input  logic              hready,
    input  logic              hresp,
    output logic [W_DATA-1:0] hwdata,
    input  logic [W_DATA-1:0] hrdata,
    output logic              busy_o
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_BADSEL
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [W_DATA-1:0] r_wdat;
    logic              r_we;
    logic              r_cycDropped;
    logic              w_error;
    logic              w_selLegal;
    logic [2:0]        w_selSize;
    logic [1:0]        w_selOffset;
    logic              w_unusedInputs;

    // Bursts are executed as single transfers, so cti/bte and the low address bits carry no information here.
    assign w_unusedInputs = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

    assign hburst    = 3'b000;
    assign hprot     = HPROT_VAL;
    assign hmastlock = 1'b0;
    assign hexcl     = 1'b0;

    always_comb begin
        w_selLegal  = 1'b1;
        w_selSize   = 3'b010;
        w_selOffset = 2'b00;
        case (wb_sel_i)
            4'b1111: ;
            4'b0011: w_selSize = 3'b001;
            4'b1100: begin w_selSize = 3'b001; w_selOffset = 2'b10; end
            4'b0001: w_selSize = 3'b000;
            4'b0010: begin w_selSize = 3'b000; w_selOffset = 2'b01; end
            4'b0100: begin w_selSize = 3'b000; w_selOffset = 2'b10; end
            4'b1000: begin w_selSize = 3'b000; w_selOffset = 2'b11; end
            default: w_selLegal = 1'b0;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_error     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i)
                    w_nextState = w_selLegal ? S_ADDR : S_BADSEL;
            end
            S_ADDR: begin
                if (hready)
                    w_nextState = S_DATA;
            end
            S_DATA: begin
                if (hresp) begin
                    w_nextState = S_RESP;
                    w_error     = 1'b1;
                end else if (hready) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP:   w_nextState = S_IDLE;
            S_BADSEL: begin
                w_nextState = S_RESP;
                w_error     = 1'b1;
            end
            default:  w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

`ifdef SD_WB2AHB_ERR_EN
    logic r_err;
    assign wb_err_o = r_err;
`else
    assign wb_err_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            haddr        <= '0;
            hwrite       <= 1'b0;
            htrans       <= HTRANS_IDLE;
            hsize        <= 3'b010;
            hwdata       <= '0;
            wb_dat_o     <= '0;
            wb_ack_o     <= 1'b0;
            busy_o       <= 1'b0;
            r_wdat       <= '0;
            r_we         <= 1'b0;
            r_cycDropped <= 1'b0;
`ifdef SD_WB2AHB_ERR_EN
            r_err        <= 1'b0;
`endif
        end else begin
            wb_ack_o <= 1'b0;
`ifdef SD_WB2AHB_ERR_EN
            r_err    <= 1'b0;
`endif
            busy_o   <= (w_nextState != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        r_wdat       <= wb_dat_i;
                        r_we         <= wb_we_i;
                        r_cycDropped <= 1'b0;
                        if (w_selLegal) begin
                            haddr  <= {wb_adr_i[W_ADDR-1:2], w_selOffset};
                            hsize  <= w_selSize;
                            hwrite <= wb_we_i;
                            htrans <= HTRANS_NONSEQ;
                        end
                    end
                end
                S_ADDR: begin
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        hwdata <= r_wdat;
                    end
                end
                S_DATA: begin
                    if (!hresp && hready && !r_we)
                        wb_dat_o <= hrdata;
                end
                default: ;
            endcase
            if (w_error && !r_we)
                wb_dat_o <= '0;
            // The AHB side cannot abort, so a dropped cyc only silences the Wishbone response.
            if ((r_state == S_ADDR || r_state == S_DATA || r_state == S_BADSEL) && !wb_cyc_i)
                r_cycDropped <= 1'b1;
            if (w_nextState == S_RESP && wb_cyc_i && !r_cycDropped) begin
`ifdef SD_WB2AHB_ERR_EN
                if (w_error)
                    r_err <= 1'b1;
                else
                    wb_ack_o <= 1'b1;
`else
                wb_ack_o <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sd_wb2ahb_master.sv
// Directed bench for sd_wb2ahb_master; expectations follow SD_WB2AHB_ERR_EN when it is defined.
module tb_sd_wb2ahb_master;

`ifdef SD_WB2AHB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [2:0]  wb_cti_i = '0;
    logic [1:0]  wb_bte_i = '0;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic        hexcl;
    logic        hready = 1'b1;
    logic        hresp  = 1'b0;
    logic [31:0] hwdata;
    logic [31:0] hrdata = '0;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    sd_wb2ahb_master dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .haddr    (haddr),
        .hwrite   (hwrite),
        .htrans   (htrans),
        .hsize    (hsize),
        .hburst   (hburst),
        .hprot    (hprot),
        .hmastlock(hmastlock),
        .hexcl    (hexcl),
        .hready   (hready),
        .hresp    (hresp),
        .hwdata   (hwdata),
        .hrdata   (hrdata),
        .busy_o   (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_cyc_i = cyc;
        wb_stb_i = stb;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge wb_clk_i);
        checkOutput("rst haddr", haddr, 32'h0);
        checkOutput("rst htrans", 32'(htrans), 32'h0);
        checkOutput("rst hsize", 32'(hsize), 32'h2);
        checkOutput("rst hwrite", 32'(hwrite), 32'h0);
        checkOutput("rst hwdata", hwdata, 32'h0);
        checkOutput("rst wb_dat_o", wb_dat_o, 32'h0);
        checkOutput("rst ack", 32'(wb_ack_o), 32'h0);
        checkOutput("rst err", 32'(wb_err_o), 32'h0);
        checkOutput("rst busy", 32'(busy_o), 32'h0);
        checkOutput("const hburst", 32'(hburst), 32'h0);
        checkOutput("const hprot", 32'(hprot), 32'h3);
        checkOutput("const lock/excl", 32'({hmastlock, hexcl}), 32'h0);
        wb_rst_i = 1'b0;

        // Word write, zero-wait slave
        @(negedge wb_clk_i);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'b1111);
        @(negedge wb_clk_i);
        checkOutput("t1 c1 htrans", 32'(htrans), 32'h2);
        checkOutput("t1 c1 haddr", haddr, 32'h2000_0010);
        checkOutput("t1 c1 hsize", 32'(hsize), 32'h2);
        checkOutput("t1 c1 hwrite", 32'(hwrite), 32'h1);
        checkOutput("t1 c1 busy", 32'(busy_o), 32'h1);
        @(negedge wb_clk_i);
        checkOutput("t1 c2 htrans", 32'(htrans), 32'h0);
        checkOutput("t1 c2 hwdata", hwdata, 32'hDEAD_BEEF);
        checkOutput("t1 c2 ack", 32'(wb_ack_o), 32'h0);
        @(negedge wb_clk_i);
        checkOutput("t1 c3 ack", 32'(wb_ack_o), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        @(negedge wb_clk_i);
        checkOutput("t1 c4 ack", 32'(wb_ack_o), 32'h0);
        checkOutput("t1 c4 busy", 32'(busy_o), 32'h0);

        // Byte read, lane 2
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b0100);
        hrdata = 32'h1122_3344;
        @(negedge wb_clk_i);
        checkOutput("t2 c1 haddr", haddr, 32'h0000_0102);
        checkOutput("t2 c1 hsize", 32'(hsize), 32'h0);
        checkOutput("t2 c1 hwrite", 32'(hwrite), 32'h0);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        checkOutput("t2 c3 ack", 32'(wb_ack_o), 32'h1);
        checkOutput("t2 c3 rdata", wb_dat_o, 32'h1122_3344);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        hrdata = 32'h0;
        @(negedge wb_clk_i);
        checkOutput("t2 c4 rdata hold", wb_dat_o, 32'h1122_3344);

        // Halfword write with wait states: 2 in address phase, 3 in data phase
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'hAABB_0000, 4'b1100);
        for (int k = 1; k <= 8; k++) begin
            @(negedge wb_clk_i);
            hready = (k == 3 || k >= 7);
            checkOutput($sformatf("t3 c%0d ack", k), 32'(wb_ack_o), (k == 8) ? 32'h1 : 32'h0);
            if (k <= 3) begin
                checkOutput($sformatf("t3 c%0d htrans", k), 32'(htrans), 32'h2);
                checkOutput($sformatf("t3 c%0d haddr", k), haddr, 32'h3000_0006);
            end
        end
        checkOutput("t3 hsize", 32'(hsize), 32'h1);
        checkOutput("t3 hwdata", hwdata, 32'hAABB_0000);
        checkOutput("t3 rdata unchanged", wb_dat_o, 32'h1122_3344);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        hready = 1'b1;
        @(negedge wb_clk_i);

        // AHB two-cycle error response on a read
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'b1111);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        hresp  = 1'b1;
        hready = 1'b0;
        hrdata = 32'hCAFE_F00D;
        @(negedge wb_clk_i);
        hready = 1'b1;
        checkOutput("t4 ack", 32'(wb_ack_o), ERR_EN ? 32'h0 : 32'h1);
        checkOutput("t4 err", 32'(wb_err_o), ERR_EN ? 32'h1 : 32'h0);
        checkOutput("t4 rdata zero", wb_dat_o, 32'h0);
        checkOutput("t4 htrans", 32'(htrans), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        @(negedge wb_clk_i);
        hresp = 1'b0;
        checkOutput("t4 c4 ack/err", 32'({wb_ack_o, wb_err_o}), 32'h0);

        // Illegal sel: no bus transfer, response after 2 cycles
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h1234_5678, 4'b0110);
        @(negedge wb_clk_i);
        checkOutput("t5 c1 htrans", 32'(htrans), 32'h0);
        checkOutput("t5 c1 busy", 32'(busy_o), 32'h1);
        checkOutput("t5 c1 ack/err", 32'({wb_ack_o, wb_err_o}), 32'h0);
        @(negedge wb_clk_i);
        checkOutput("t5 c2 htrans", 32'(htrans), 32'h0);
        checkOutput("t5 c2 ack", 32'(wb_ack_o), ERR_EN ? 32'h0 : 32'h1);
        checkOutput("t5 c2 err", 32'(wb_err_o), ERR_EN ? 32'h1 : 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        @(negedge wb_clk_i);
        checkOutput("t5 c3 ack/err", 32'({wb_ack_o, wb_err_o}), 32'h0);

        // Reset asserted during the data phase
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'b1111);
        @(negedge wb_clk_i);
        checkOutput("t6 c1 htrans", 32'(htrans), 32'h2);
        @(negedge wb_clk_i);
        hready   = 1'b0;
        wb_rst_i = 1'b1;
        #1;
        checkOutput("t6 rst htrans", 32'(htrans), 32'h0);
        checkOutput("t6 rst busy", 32'(busy_o), 32'h0);
        checkOutput("t6 rst ack", 32'(wb_ack_o), 32'h0);
        checkOutput("t6 rst haddr", haddr, 32'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        hready   = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        @(negedge wb_clk_i);
        checkOutput("t6 post ack", 32'(wb_ack_o), 32'h0);

        // Top-of-memory word write after reset release
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'b1111);
        @(negedge wb_clk_i);
        checkOutput("t7 c1 haddr", haddr, 32'hFFFF_FFFC);
        checkOutput("t7 c1 htrans", 32'(htrans), 32'h2);
        @(negedge wb_clk_i);
        checkOutput("t7 c2 hwdata", hwdata, 32'h1234_5678);
        @(negedge wb_clk_i);
        checkOutput("t7 c3 ack", 32'(wb_ack_o), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        @(negedge wb_clk_i);

        // cyc dropped while the address phase is stalled: AHB completes, no ack
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'b0001);
        @(negedge wb_clk_i);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        hready = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("t8 c2 htrans held", 32'(htrans), 32'h2);
        checkOutput("t8 c2 haddr", haddr, 32'h0000_0700);
        hready = 1'b1;
        @(negedge wb_clk_i);
        checkOutput("t8 c3 htrans", 32'(htrans), 32'h0);
        @(negedge wb_clk_i);
        checkOutput("t8 c4 ack", 32'(wb_ack_o), 32'h0);
        checkOutput("t8 c4 err", 32'(wb_err_o), 32'h0);
        @(negedge wb_clk_i);
        checkOutput("t8 c5 busy", 32'(busy_o), 32'h0);

        // Byte read, lane 3
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0804, 32'h0, 4'b1000);
        hrdata = 32'h9900_AABB;
        @(negedge wb_clk_i);
        checkOutput("t9 c1 haddr", haddr, 32'h0000_0807);
        checkOutput("t9 c1 hsize", 32'(hsize), 32'h0);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        checkOutput("t9 c3 ack", 32'(wb_ack_o), 32'h1);
        checkOutput("t9 c3 rdata", wb_dat_o, 32'h9900_AABB);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        @(negedge wb_clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
